// File: rtl/ehgu_dp_rr_scheduler.sv
// ehgu_dp_rr_scheduler: round-robin scheduler sharing one
// multi-cycle ehgu datapath among NUM_REQ requesters.

package ehgu_config_pkg;
  localparam int DP_WIDTH = 32;
endpackage

module ehgu_dp_rr_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int DP_WIDTH  = ehgu_config_pkg::DP_WIDTH,
  parameter int MAX_BURST = 1,
  parameter int TIMEOUT   = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*DP_WIDTH-1:0] req_op0,
  input  logic [NUM_REQ*DP_WIDTH-1:0] req_op1,
  output logic                    dp_start,
  output logic [DP_WIDTH-1:0]     dp_op0,
  output logic [DP_WIDTH-1:0]     dp_op1,
  input  logic                    dp_done,
  input  logic [DP_WIDTH-1:0]     dp_result,
  output logic [NUM_REQ-1:0]      rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic [DP_WIDTH-1:0]     rsp_data,
  output logic                    rsp_err,
  output logic                    busy
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [PW-1:0]       last_g_q, last_g_d;
  logic [PW-1:0]       gnt_q, gnt_d;
  logic [BW-1:0]       burst_q, burst_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic [DP_WIDTH-1:0] op0_q, op0_d;
  logic [DP_WIDTH-1:0] op1_q, op1_d;
  logic                start_q, start_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DP_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;
  logic                busy_q, busy_d;

  logic                found;
  logic [PW-1:0]       g;
  logic [PW:0]         idx;
  logic [BW:0]         burst_n;

  // Search for the first valid requester starting at ptr, wrapping by compare
  always_comb begin
    found = 1'b0;
    g     = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr_q} + (PW+1)'(k);
      if (idx >= (PW+1)'(NUM_REQ)) idx = idx - (PW+1)'(NUM_REQ);
      if (!found && req_valid[idx[PW-1:0]]) begin
        found = 1'b1;
        g     = idx[PW-1:0];
      end
    end
  end

  // Accept strobe to the winner while idle
  always_comb begin
    req_ready = '0;
    if (rst_n && state_q == IDLE && found) req_ready[g] = 1'b1;
  end

  // Next-state, pointer/burst bookkeeping and registered outputs
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    last_g_d    = last_g_q;
    gnt_d       = gnt_q;
    burst_d     = burst_q;
    tmo_d       = tmo_q;
    op0_d       = op0_q;
    op1_d       = op1_q;
    start_d     = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    burst_n     = (g == last_g_q) ? ({1'b0, burst_q} + 1'b1)
                                  : (BW+1)'(1);
    unique case (state_q)
      IDLE: begin
        if (found) begin
          op0_d    = req_op0[int'(g)*DP_WIDTH +: DP_WIDTH];
          op1_d    = req_op1[int'(g)*DP_WIDTH +: DP_WIDTH];
          gnt_d    = g;
          last_g_d = g;
          if (burst_n >= (BW+1)'(MAX_BURST)) begin
            ptr_d   = (g == PW'(NUM_REQ-1)) ? '0 : g + 1'b1;
            burst_d = '0;
          end else begin
            ptr_d   = g;
            burst_d = burst_n[BW-1:0];
          end
          start_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (dp_done) begin
          rsp_data_d         = dp_result;
          rsp_err_d          = 1'b0;
          rsp_valid_d        = '0;
          rsp_valid_d[gnt_q] = 1'b1;
          state_d            = RESP;
        end else if (tmo_q == TW'(TIMEOUT-1)) begin
          rsp_data_d         = '0;
          rsp_err_d          = 1'b1;
          rsp_valid_d        = '0;
          rsp_valid_d[gnt_q] = 1'b1;
          state_d            = RESP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready[gnt_q]) begin
          rsp_valid_d = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      last_g_q    <= '0;
      gnt_q       <= '0;
      burst_q     <= '0;
      tmo_q       <= '0;
      op0_q       <= '0;
      op1_q       <= '0;
      start_q     <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      last_g_q    <= last_g_d;
      gnt_q       <= gnt_d;
      burst_q     <= burst_d;
      tmo_q       <= tmo_d;
      op0_q       <= op0_d;
      op1_q       <= op1_d;
      start_q     <= start_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
    end
  end

  assign dp_start  = start_q;
  assign dp_op0    = op0_q;
  assign dp_op1    = op1_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;

endmodule
